// File: rtl/usd_sensor_array.sv
// Round-robin driver for NUM_CH HC-SR04-style ultrasonic sensors.
// Fires one channel at a time, measures its echo width in us and reports a tagged result per channel.
//
// state       | meaning
// ------------+---------------------------------------------------------------
// S_IDLE      | no sweep in progress, waiting for start
// S_TRIG      | trigger pulse high on the active channel
// S_WAIT_RISE | waiting for a fresh rising edge of the active echo
// S_MEASURE   | echo high, counting microseconds until it falls
// S_HOLDOFF   | quiet gap before the next channel fires
module usd_sensor_array #(
    parameter int NUM_CH      = 4,
    parameter int CLKS_PER_US = 50,
    parameter int TRIG_US     = 10,
    parameter int TIMEOUT_US  = 30000,
    parameter int HOLDOFF_US  = 60000,
    parameter int OUT_W       = 16,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_50mhz,
    input  logic              reset,
    input  logic              start,
    input  logic              auto_mode,
    input  logic [NUM_CH-1:0] sensor_in,
    output logic [NUM_CH-1:0] sensor_trigger,
    output logic              busy,
    output logic              sample_valid,
    output logic [CH_W-1:0]   sample_ch,
    output logic [OUT_W-1:0]  sample_us,
    output logic              sample_timeout
);

    localparam int MAX_A  = (TRIG_US > TIMEOUT_US) ? TRIG_US : TIMEOUT_US;
    localparam int MAX_US = (MAX_A > HOLDOFF_US) ? MAX_A : HOLDOFF_US;
    localparam int US_W   = $clog2(MAX_US + 1);
    localparam int PRE_W  = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST     = PRE_W'(CLKS_PER_US - 1);
    localparam logic [US_W-1:0]  TRIG_LAST    = US_W'(TRIG_US - 1);
    localparam logic [US_W-1:0]  TIMEOUT_LAST = US_W'(TIMEOUT_US - 1);
    localparam logic [US_W-1:0]  HOLDOFF_LAST = US_W'(HOLDOFF_US - 1);
    localparam logic [CH_W-1:0]  LAST_CH      = CH_W'(NUM_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_RISE,
        S_MEASURE,
        S_HOLDOFF
    } state_t;

    state_t             state_q, state_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [US_W-1:0]    us_q, us_d;
    logic [NUM_CH-1:0]  sync1_q, sync1_d;
    logic [NUM_CH-1:0]  sync2_q, sync2_d;
    logic [NUM_CH-1:0]  sync3_q, sync3_d;
    logic               echo_prev_q, echo_prev_d;
    logic [NUM_CH-1:0]  trig_q, trig_d;
    logic               busy_q, busy_d;
    logic               valid_q, valid_d;
    logic [CH_W-1:0]    sample_ch_q, sample_ch_d;
    logic [OUT_W-1:0]   sample_us_q, sample_us_d;
    logic               sample_to_q, sample_to_d;

    logic echo_now;
    logic echo_rise;
    logic echo_fall;
    logic tick;
    logic at_timeout;

    // Only the active channel's synchronised echo is ever looked at.
    assign echo_now   = sync3_q[ch_q];
    assign echo_rise  = echo_now & ~echo_prev_q;
    assign echo_fall  = ~echo_now & echo_prev_q;
    assign tick       = (pre_q == PRE_LAST);
    assign at_timeout = tick && (us_q == TIMEOUT_LAST);

    always_comb begin
        sync1_d     = sensor_in;
        sync2_d     = sync1_q;
        sync3_d     = sync2_q;
        echo_prev_d = echo_now;
        state_d     = state_q;
        ch_d        = ch_q;
        pre_d       = tick ? '0 : pre_q + PRE_W'(1);
        us_d        = tick ? us_q + US_W'(1) : us_q;
        trig_d      = trig_q;
        valid_d     = 1'b0;
        sample_ch_d = sample_ch_q;
        sample_us_d = sample_us_q;
        sample_to_d = sample_to_q;

        case (state_q)
            S_IDLE: begin
                pre_d = '0;
                us_d  = '0;
                if (start) begin
                    ch_d      = '0;
                    trig_d    = '0;
                    trig_d[0] = 1'b1;
                    state_d   = S_TRIG;
                end
            end
            S_TRIG: begin
                if (tick && us_q == TRIG_LAST) begin
                    trig_d  = '0;
                    state_d = S_WAIT_RISE;
                end
            end
            S_WAIT_RISE: begin
                if (at_timeout) begin
                    valid_d     = 1'b1;
                    sample_ch_d = ch_q;
                    sample_us_d = OUT_W'(TIMEOUT_US);
                    sample_to_d = 1'b1;
                    state_d     = S_HOLDOFF;
                end else if (echo_rise) begin
                    state_d = S_MEASURE;
                end
            end
            S_MEASURE: begin
                // Timeout is tested first so it wins over a coincident fall.
                if (at_timeout) begin
                    valid_d     = 1'b1;
                    sample_ch_d = ch_q;
                    sample_us_d = OUT_W'(TIMEOUT_US);
                    sample_to_d = 1'b1;
                    state_d     = S_HOLDOFF;
                end else if (echo_fall) begin
                    valid_d     = 1'b1;
                    sample_ch_d = ch_q;
                    sample_us_d = OUT_W'(us_q);
                    sample_to_d = 1'b0;
                    state_d     = S_HOLDOFF;
                end
            end
            S_HOLDOFF: begin
                if (tick && us_q == HOLDOFF_LAST) begin
                    if (ch_q != LAST_CH) begin
                        ch_d         = ch_q + CH_W'(1);
                        trig_d       = '0;
                        trig_d[ch_d] = 1'b1;
                        state_d      = S_TRIG;
                    end else if (auto_mode) begin
                        ch_d      = '0;
                        trig_d    = '0;
                        trig_d[0] = 1'b1;
                        state_d   = S_TRIG;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                trig_d  = '0;
                state_d = S_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            pre_d = '0;
            us_d  = '0;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            pre_q       <= '0;
            us_q        <= '0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            sync3_q     <= '0;
            echo_prev_q <= 1'b0;
            trig_q      <= '0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            sample_ch_q <= '0;
            sample_us_q <= '0;
            sample_to_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            pre_q       <= pre_d;
            us_q        <= us_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            sync3_q     <= sync3_d;
            echo_prev_q <= echo_prev_d;
            trig_q      <= trig_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            sample_ch_q <= sample_ch_d;
            sample_us_q <= sample_us_d;
            sample_to_q <= sample_to_d;
        end
    end

    assign sensor_trigger = trig_q;
    assign busy           = busy_q;
    assign sample_valid   = valid_q;
    assign sample_ch      = sample_ch_q;
    assign sample_us      = sample_us_q;
    assign sample_timeout = sample_to_q;

endmodule

// File: tb/tb_usd_sensor_array.sv
// Bench for usd_sensor_array: per-channel echo responders, a result model derived from echo lengths,
// and a per-cycle checker for trigger shape, channel order, busy and every reported sample.
`timescale 1ns/1ps
module tb_usd_sensor_array;

    localparam int NCH  = 4;
    localparam int CPU  = 5;
    localparam int TRG  = 10;
    localparam int TO   = 100;
    localparam int HO   = 20;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           auto_mode;
    logic [NCH-1:0] sensor_in;
    logic [NCH-1:0] sensor_trigger;
    logic           busy;
    logic           sample_valid;
    logic [1:0]     sample_ch;
    logic [15:0]    sample_us;
    logic           sample_timeout;

    usd_sensor_array #(
        .NUM_CH(NCH), .CLKS_PER_US(CPU), .TRIG_US(TRG),
        .TIMEOUT_US(TO), .HOLDOFF_US(HO), .OUT_W(16)
    ) dut (
        .clk_50mhz     (clk),
        .reset         (reset),
        .start         (start),
        .auto_mode     (auto_mode),
        .sensor_in     (sensor_in),
        .sensor_trigger(sensor_trigger),
        .busy          (busy),
        .sample_valid  (sample_valid),
        .sample_ch     (sample_ch),
        .sample_us     (sample_us),
        .sample_timeout(sample_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        bit to;
        int us;
        int kind;     // 0 normal, 1 no echo, 2 echo too long
        int ref_cyc;
    } exp_t;

    exp_t     q[$];
    int       n_checks = 0;
    int       n_errs   = 0;
    int       n_strobe = 0;
    int       cyc      = 0;
    int       cfg_dly [NCH];
    int       cfg_len [NCH];
    int       rec_us  [NCH];
    int       rec_to  [NCH];
    logic [NCH-1:0] static_high;

    task automatic chk(input string name, input bit ok, input int act, input int req);
        n_checks++;
        if (!ok) begin
            n_errs++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Echo responders plus per-cycle checker, in one process.
    initial begin : model_proc
        int       dly_cnt [NCH];
        int       len_cnt [NCH];
        logic [NCH-1:0] echo_v;
        logic [NCH-1:0] prev_r;
        logic [NCH-1:0] prev_c;
        int       run;
        int       model_ch;
        exp_t     e;
        for (int c = 0; c < NCH; c++) begin
            dly_cnt[c] = -1;
            len_cnt[c] = 0;
        end
        echo_v    = '0;
        prev_r    = '0;
        prev_c    = '0;
        run       = 0;
        model_ch  = 0;
        sensor_in = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            for (int c = 0; c < NCH; c++) begin
                if (!reset && prev_r[c] && !sensor_trigger[c]) begin
                    e.ch = c;
                    if (cfg_dly[c] < 0) begin
                        e.to = 1'b1; e.us = TO; e.kind = 1; e.ref_cyc = cyc;
                    end else begin
                        dly_cnt[c] = cfg_dly[c];
                        len_cnt[c] = cfg_len[c];
                        if (cfg_len[c] >= TO * CPU) begin
                            e.to = 1'b1; e.us = TO; e.kind = 2; e.ref_cyc = cyc + cfg_dly[c];
                        end else begin
                            e.to = 1'b0; e.us = cfg_len[c] / CPU; e.kind = 0; e.ref_cyc = 0;
                        end
                    end
                    q.push_back(e);
                end
                if (dly_cnt[c] > 0) begin
                    dly_cnt[c]--;
                end else if (dly_cnt[c] == 0) begin
                    echo_v[c]  = 1'b1;
                    dly_cnt[c] = -1;
                end else if (len_cnt[c] > 0) begin
                    len_cnt[c]--;
                    if (len_cnt[c] == 0) echo_v[c] = 1'b0;
                end
                prev_r[c] = sensor_trigger[c];
            end
            sensor_in = echo_v | static_high;

            @(negedge clk);
            if (reset) begin
                prev_c   = '0;
                run      = 0;
                model_ch = 0;
            end else begin
                if (!busy) model_ch = 0;
                chk("trig_onehot", $countones(sensor_trigger) <= 1, $countones(sensor_trigger), 1);
                if (sensor_trigger != '0 || sample_valid)
                    chk("busy_when_active", busy == 1'b1, busy, 1);
                if (sensor_trigger != '0 && prev_c == '0) begin
                    chk("trig_channel", sensor_trigger == NCH'(1 << model_ch), sensor_trigger, 1 << model_ch);
                    model_ch = (model_ch + 1) % NCH;
                    run = 0;
                end
                if (sensor_trigger != '0) run++;
                if (sensor_trigger == '0 && prev_c != '0)
                    chk("trig_width", run == TRG * CPU, run, TRG * CPU);
                if (sample_valid) begin
                    n_strobe++;
                    rec_us[sample_ch] = sample_us;
                    rec_to[sample_ch] = sample_timeout;
                    if (q.size() == 0) begin
                        chk("unexpected_strobe", 1'b0, sample_ch, -1);
                    end else begin
                        e = q.pop_front();
                        chk("strobe_ch", sample_ch == e.ch, sample_ch, e.ch);
                        chk("strobe_timeout", sample_timeout == e.to, sample_timeout, e.to);
                        if (e.to)
                            chk("strobe_us_sat", sample_us == e.us, sample_us, e.us);
                        else
                            chk("strobe_us", (sample_us + 1 >= e.us) && (sample_us <= e.us + 1), sample_us, e.us);
                        if (e.kind == 1)
                            chk("norise_latency", (cyc - e.ref_cyc >= 499) && (cyc - e.ref_cyc <= 501),
                                cyc - e.ref_cyc, 500);
                        if (e.kind == 2)
                            chk("longecho_latency", (cyc - e.ref_cyc >= 502) && (cyc - e.ref_cyc <= 506),
                                cyc - e.ref_cyc, 504);
                    end
                end
                prev_c = sensor_trigger;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_trig(input int c, input bit level, input int budget);
        int n = 0;
        while (sensor_trigger[c] != level && n < budget) begin
            step(1);
            n++;
        end
        chk($sformatf("wait_trig%0d_%0d", c, level), sensor_trigger[c] == level, n, budget);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            step(1);
            n++;
        end
        chk("wait_idle", busy == 1'b0, n, budget);
    endtask

    task automatic wait_strobes(input int target, input int budget);
        int n = 0;
        while (n_strobe < target && n < budget) begin
            step(1);
            n++;
        end
        chk("wait_strobes", n_strobe >= target, n_strobe, target);
    endtask

    task automatic set_all(input int dly, input int len);
        for (int c = 0; c < NCH; c++) begin
            cfg_dly[c] = dly;
            cfg_len[c] = len;
        end
    endtask

    initial begin : main_proc
        int base;
        reset       = 1'b1;
        start       = 1'b0;
        auto_mode   = 1'b0;
        static_high = '0;
        set_all(5, 25);
        for (int c = 0; c < NCH; c++) begin
            rec_us[c] = -1;
            rec_to[c] = -1;
        end
        step(3);
        chk("rst_trigger", sensor_trigger == '0, sensor_trigger, 0);
        chk("rst_busy", busy == 1'b0, busy, 0);
        chk("rst_valid", sample_valid == 1'b0, sample_valid, 0);
        chk("rst_sample_ch", sample_ch == 2'd0, sample_ch, 0);
        chk("rst_sample_us", sample_us == 16'd0, sample_us, 0);
        chk("rst_sample_to", sample_timeout == 1'b0, sample_timeout, 0);
        reset = 1'b0;
        step(2);

        // Reset in the middle of channel 2's trigger pulse.
        set_all(10, 50);
        pulse_start();
        wait_trig(2, 1'b1, 3000);
        step(10);
        chk("pre_reset_strobes", n_strobe == 2, n_strobe, 2);
        reset = 1'b1;
        step(1);
        chk("midrst_trigger", sensor_trigger == '0, sensor_trigger, 0);
        chk("midrst_busy", busy == 1'b0, busy, 0);
        chk("midrst_valid", sample_valid == 1'b0, sample_valid, 0);
        base = n_strobe;
        step(2);
        reset = 1'b0;
        step(300);
        chk("no_partial_result", n_strobe == base, n_strobe, base);
        chk("no_pending_expect", q.size() == 0, q.size(), 0);
        chk("idle_after_reset", busy == 1'b0, busy, 0);

        // Single sweep, ch0 echo 30 cycles after trigger, 200 cycles wide.
        set_all(5, 25);
        cfg_dly[0] = 30; cfg_len[0] = 200;
        base = n_strobe;
        pulse_start();
        wait_idle(6000);
        chk("sweep1_strobes", n_strobe == base + 4, n_strobe - base, 4);
        chk("ch0_40us", rec_us[0] >= 39 && rec_us[0] <= 41, rec_us[0], 40);
        chk("ch0_no_to", rec_to[0] == 0, rec_to[0], 0);

        // Full sweep with ch1 silent.
        set_all(10, 100);
        cfg_dly[1] = -1;
        base = n_strobe;
        pulse_start();
        wait_idle(6000);
        chk("sweep2_strobes", n_strobe == base + 4, n_strobe - base, 4);
        chk("ch1_to_us", rec_us[1] == 100, rec_us[1], 100);
        chk("ch1_to_flag", rec_to[1] == 1, rec_to[1], 1);
        chk("ch3_20us", rec_us[3] >= 19 && rec_us[3] <= 21, rec_us[3], 20);
        chk("sweep2_trig_off", sensor_trigger == '0, sensor_trigger, 0);

        // Long echoes: just under, exactly at, and beyond the timeout.
        cfg_dly[0] = 5;  cfg_len[0] = 499;
        cfg_dly[1] = 5;  cfg_len[1] = 100;
        cfg_dly[2] = 10; cfg_len[2] = 600;
        cfg_dly[3] = 5;  cfg_len[3] = 500;
        base = n_strobe;
        pulse_start();
        wait_idle(8000);
        chk("sweep3_strobes", n_strobe == base + 4, n_strobe - base, 4);
        chk("ch0_99us", rec_us[0] >= 98 && rec_us[0] <= 100, rec_us[0], 99);
        chk("ch0_499_no_to", rec_to[0] == 0, rec_to[0], 0);
        chk("ch2_sat_us", rec_us[2] == 100, rec_us[2], 100);
        chk("ch2_sat_to", rec_to[2] == 1, rec_to[2], 1);
        chk("ch3_edge_to", rec_to[3] == 1, rec_to[3], 1);

        // Auto mode for two sweeps, cleared during ch1 of the third.
        step(200);
        set_all(5, 25);
        auto_mode = 1'b1;
        base = n_strobe;
        pulse_start();
        wait_strobes(base + 8, 6000);
        wait_trig(1, 1'b1, 3000);
        auto_mode = 1'b0;
        wait_idle(4000);
        chk("auto_strobes", n_strobe == base + 12, n_strobe - base, 12);
        step(300);
        chk("auto_stays_idle", busy == 1'b0 && n_strobe == base + 12, n_strobe - base, 12);

        // Echo already high before ch0 fires, plus start pulses while busy.
        set_all(5, 25);
        cfg_dly[0] = 30; cfg_len[0] = 100;
        static_high[0] = 1'b1;
        step(20);
        base = n_strobe;
        pulse_start();
        wait_trig(0, 1'b1, 100);
        step(20);
        pulse_start();
        wait_trig(0, 1'b0, 100);
        step(10);
        static_high[0] = 1'b0;
        wait_trig(1, 1'b1, 3000);
        pulse_start();
        wait_idle(6000);
        chk("busy_start_strobes", n_strobe == base + 4, n_strobe - base, 4);
        chk("fresh_rise_ch0", rec_us[0] >= 19 && rec_us[0] <= 21, rec_us[0], 20);
        chk("queue_drained", q.size() == 0, q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errs);
        $fatal(1, "watchdog expired");
    end

endmodule
